// File: rtl/add_pkg.sv
// Shared types and sizing for the byte-serial adder sequencer.
package add_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;

  localparam int ADD_WIDTH = 32;
  localparam int ADD_SLICE = 8;

endpackage

// File: rtl/prefix_adder_8bit.sv
// 8-bit Kogge-Stone prefix adder with carry-in; the per-cycle byte engine of the sequencer.
module prefix_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen [4];
  logic [7:0] prop [4];
  logic [7:0] carries;

  // Fold cin into bit 0 generate so the prefix tree yields carries directly.
  always_comb begin
    gen[0]    = a & b;
    gen[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    prop[0]   = a ^ b;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) begin
        if (i >= (1 << l)) begin
          gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i-(1<<l)]);
          prop[l+1][i] = prop[l][i] & prop[l][i-(1<<l)];
        end else begin
          gen[l+1][i]  = gen[l][i];
          prop[l+1][i] = prop[l][i];
        end
      end
    end
    carries = {gen[3][6:0], cin};
    sum     = prop[0] ^ carries;
    cout    = gen[3][7];
  end

endmodule

// File: rtl/serial_add32_seq.sv
// Byte-serial WIDTH-bit adder: latches an operand pair, adds one SLICE per cycle
// through a shared byte adder with a registered carry, then presents the result.
module serial_add32_seq
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int SLICE = ADD_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  seq_state_t       state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             cout_q, ovf_q;
  logic             accept;

  logic [SLICE-1:0] a_slice, b_slice, slice_sum;
  logic             slice_cout;

  assign a_slice = a_q[idx_q*SLICE +: SLICE];
  assign b_slice = b_q[idx_q*SLICE +: SLICE];

  prefix_adder_8bit u_byte_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // DONE doubles as an accept slot so back-to-back ops cost only one extra cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      idx_q   <= '0;
    end else if (state_q == S_RUN) begin
      result_q[idx_q*SLICE +: SLICE] <= slice_sum;
      carry_q <= slice_cout;
      idx_q   <= idx_q + 1'b1;
      // Top slice: its carry and sign bit become the flags.
      if (idx_q == LAST_IDX) begin
        cout_q <= slice_cout;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign out_sum  = result_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add32_seq.sv
// Scoreboard bench for serial_add32_seq: directed corner cases plus throttled random traffic.
module tb_serial_add32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  int   pop_cyc    = 0;
  int   pushes = 0;
  int   pops   = 0;
  bit   accepted;

  serial_add32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] full;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    return e;
  endfunction

  // One clock cycle: drive at negedge, log both handshakes, return just after posedge.
  task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    out_ready = ordy;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sum",  {32'd0, out_sum},  {32'd0, e.sum});
        checkOutput("cout", {63'd0, out_cout}, {63'd0, e.cout});
        checkOutput("ovf",  {63'd0, out_ovf},  {63'd0, e.ovf});
        pops++;
        pop_cyc = cyc;
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(a, b, c));
      pushes++;
      accepted   = 1'b1;
      accept_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pushOp(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic ordy);
    int tries;
    tries = 0;
    accepted = 1'b0;
    while (!accepted && tries < 20) begin
      applyStimulus(1'b1, a, b, c, ordy);
      tries++;
    end
    checkOutput("accept", {63'd0, accepted}, 64'd1);
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (sb.size() != 0 && tries < 40) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      tries++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic c);
    pushOp(a, b, c, 1'b1);
    checkOutput("busy_run", {63'd0, busy}, 64'd1);
    checkOutput("in_ready_run", {63'd0, in_ready}, 64'd0);
    drain();
    checkOutput("latency", 64'(pop_cyc - accept_cyc), 64'd5);
  endtask

  initial begin
    logic [31:0] held_sum;
    bit          stable;
    int          tries;
    int          sent;
    bit          pend;
    bit          ivld;
    logic [31:0] ra, rb;
    logic        rc;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  {63'd0, in_ready},  64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_sum",       {32'd0, out_sum},   64'd0);
    checkOutput("rst_busy",      {63'd0, busy},      64'd0);
    rst = 1'b0;

    $display("[TB] directed adds");
    runOp(32'h0000_0001, 32'h0000_0001, 1'b0);
    runOp(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    runOp(32'h8000_0000, 32'h8000_0000, 1'b0);

    $display("[TB] backpressure and back-to-back");
    pushOp(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    tries = 0;
    while (!out_valid && tries < 20) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tries++;
    end
    checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
    held_sum = out_sum;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      if (out_sum !== held_sum || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    checkOutput("bp_stable", {63'd0, stable}, 64'd1);
    checkOutput("bp_sum", {32'd0, held_sum}, 64'h7);
    applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    checkOutput("b2b_accept", {63'd0, accepted}, 64'd1);
    drain();
    checkOutput("b2b_latency", 64'(pop_cyc - accept_cyc), 64'd5);

    $display("[TB] reset mid-op");
    pushOp(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    checkOutput("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_sum",       {32'd0, out_sum},   64'd0);
    checkOutput("mid_rst_cout",      {63'd0, out_cout},  64'd0);
    checkOutput("mid_rst_ovf",       {63'd0, out_ovf},   64'd0);
    checkOutput("mid_rst_busy",      {63'd0, busy},      64'd0);
    sb.delete();
    pushes = pushes - 1;
    repeat (2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (8) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("no_out_after_rst", {63'd0, out_valid}, 64'd0);
    runOp(32'h0000_00FF, 32'h0000_0001, 1'b0);

    $display("[TB] random traffic");
    sent  = 0;
    pend  = 1'b0;
    ivld  = 1'b0;
    tries = 0;
    ra = '0; rb = '0; rc = 1'b0;
    while (sent < 1000 && tries < 40000) begin
      if (!pend) begin
        ra   = $urandom();
        rb   = $urandom();
        rc   = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      if (!ivld) ivld = ($urandom_range(0, 3) != 0);
      applyStimulus(ivld, ra, rb, rc, ($urandom_range(0, 3) != 0));
      if (accepted) begin
        pend = 1'b0;
        ivld = 1'b0;
        sent++;
      end
      tries++;
    end
    checkOutput("rand_sent", 64'(sent), 64'd1000);
    drain();
    checkOutput("no_lost_results", 64'(pops), 64'(pushes));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
